// File: rtl/zxuno_regmaster_pkg.sv
// Shared types and constants for the ZX-UNO register bus master.
// Holds the sequencer state encoding, default port addresses and the phase-counter width helper.
package zxuno_regmaster_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_SETUP  = 3'd1,
        A_STROBE = 3'd2,
        A_HOLD   = 3'd3,
        D_SETUP  = 3'd4,
        D_STROBE = 3'd5,
        D_HOLD   = 3'd6,
        DONE     = 3'd7
    } state_e;

    localparam logic [15:0] IOADDR_DEFAULT = 16'hFC3B;
    localparam logic [15:0] IODATA_DEFAULT = 16'hFD3B;

    // Width needed to hold PHASE_CLKS-1 with room for PHASE_CLKS=1.
    function automatic int phase_cnt_width(input int phase_clks);
        return $clog2(phase_clks + 1);
    endfunction

endpackage

// File: rtl/zxuno_phase_timer.sv
// Loadable down-counter that times one bus phase of the register master.
// tc is high on the last cycle of a phase; load restarts the phase at PHASE_CLKS-1.
module zxuno_phase_timer
    import zxuno_regmaster_pkg::*;
#(
    parameter int PHASE_CLKS = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tc
);

    localparam int            CW     = phase_cnt_width(PHASE_CLKS);
    localparam logic [CW-1:0] RELOAD = CW'(PHASE_CLKS - 1);
    localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] count_r;

    // Count down to zero and park there until the next state change reloads it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= RELOAD;
        end else if (load) begin
            count_r <= RELOAD;
        end else if (count_r != ZERO) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == ZERO);

endmodule

// File: rtl/zxuno_regmaster.sv
// Z80-style I/O bus master: writes a register index to IOADDR, then writes or reads IODATA.
// Optional last-index cache enabled by defining ZXUNO_REGMASTER_ADDRCACHE_EN.
module zxuno_regmaster
    import zxuno_regmaster_pkg::*;
#(
    parameter logic [15:0] IOADDR     = IOADDR_DEFAULT,
    parameter logic [15:0] IODATA     = IODATA_DEFAULT,
    parameter int          PHASE_CLKS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        rw,
    input  logic [7:0]  reg_addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [15:0] a,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic [7:0]  dout,
    output logic        dout_oe,
    input  logic [7:0]  din
);

    state_e      state_r;
    state_e      next_s;
    logic        tc_s;
    logic        load_s;
    logic        hit_s;

    logic        rw_r;
    logic [7:0]  reg_addr_r;
    logic [7:0]  wdata_r;

    logic        op_rw_s;
    logic [7:0]  op_addr_s;
    logic [7:0]  op_wdata_s;

    logic [15:0] a_r;
    logic        iorq_n_r;
    logic        rd_n_r;
    logic        wr_n_r;
    logic [7:0]  dout_r;
    logic        dout_oe_r;
    logic        busy_r;
    logic        done_r;
    logic [7:0]  rdata_r;

    logic [15:0] a_s;
    logic        iorq_n_s;
    logic        rd_n_s;
    logic        wr_n_s;
    logic [7:0]  dout_s;
    logic        dout_oe_s;

    zxuno_phase_timer #(
        .PHASE_CLKS (PHASE_CLKS)
    ) u_phase_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .tc    (tc_s)
    );

    assign load_s = (next_s != state_r);

`ifdef ZXUNO_REGMASTER_ADDRCACHE_EN
    logic [7:0] cache_idx_r;
    logic       cache_valid_r;

    // Remember the index once the slave has latched it at the end of the A phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cache_idx_r   <= 8'h00;
            cache_valid_r <= 1'b0;
        end else if ((state_r == A_HOLD) && tc_s) begin
            cache_idx_r   <= reg_addr_r;
            cache_valid_r <= 1'b1;
        end else begin
            cache_idx_r   <= cache_idx_r;
            cache_valid_r <= cache_valid_r;
        end
    end

    assign hit_s = cache_valid_r && (reg_addr == cache_idx_r);
`else
    assign hit_s = 1'b0;
`endif

    // On the accepting edge the capture registers are not loaded yet, so use the live inputs.
    assign op_rw_s    = (state_r == IDLE) ? rw       : rw_r;
    assign op_addr_s  = (state_r == IDLE) ? reg_addr : reg_addr_r;
    assign op_wdata_s = (state_r == IDLE) ? wdata    : wdata_r;

    // Next-state logic: each bus phase advances on the timer's terminal count.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    next_s = hit_s ? D_SETUP : A_SETUP;
                end else begin
                    next_s = IDLE;
                end
            end
            A_SETUP:  next_s = tc_s ? A_STROBE : A_SETUP;
            A_STROBE: next_s = tc_s ? A_HOLD   : A_STROBE;
            A_HOLD:   next_s = tc_s ? D_SETUP  : A_HOLD;
            D_SETUP:  next_s = tc_s ? D_STROBE : D_SETUP;
            D_STROBE: next_s = tc_s ? D_HOLD   : D_STROBE;
            D_HOLD:   next_s = tc_s ? DONE     : D_HOLD;
            DONE:     next_s = IDLE;
            default:  next_s = IDLE;
        endcase
    end

    // Bus values for the state being entered, so the registered outputs line up with the state.
    always_comb begin
        a_s       = a_r;
        dout_s    = dout_r;
        dout_oe_s = dout_oe_r;
        iorq_n_s  = 1'b1;
        rd_n_s    = 1'b1;
        wr_n_s    = 1'b1;
        case (next_s)
            IDLE: begin
                dout_oe_s = 1'b0;
            end
            A_SETUP, A_STROBE, A_HOLD: begin
                a_s       = IOADDR;
                dout_s    = op_addr_s;
                dout_oe_s = 1'b1;
                if (next_s == A_STROBE) begin
                    iorq_n_s = 1'b0;
                    wr_n_s   = 1'b0;
                end else begin
                    iorq_n_s = 1'b1;
                    wr_n_s   = 1'b1;
                end
            end
            D_SETUP, D_STROBE, D_HOLD: begin
                a_s = IODATA;
                if (op_rw_s) begin
                    dout_s    = op_wdata_s;
                    dout_oe_s = 1'b1;
                end else begin
                    dout_oe_s = 1'b0;
                end
                if (next_s == D_STROBE) begin
                    iorq_n_s = 1'b0;
                    wr_n_s   = ~op_rw_s;
                    rd_n_s   = op_rw_s;
                end else begin
                    iorq_n_s = 1'b1;
                    wr_n_s   = 1'b1;
                    rd_n_s   = 1'b1;
                end
            end
            DONE: begin
                dout_oe_s = dout_oe_r;
            end
            default: begin
                dout_oe_s = 1'b0;
            end
        endcase
    end

    // State, request capture and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            rw_r       <= 1'b0;
            reg_addr_r <= 8'h00;
            wdata_r    <= 8'h00;
            a_r        <= 16'h0000;
            iorq_n_r   <= 1'b1;
            rd_n_r     <= 1'b1;
            wr_n_r     <= 1'b1;
            dout_r     <= 8'h00;
            dout_oe_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rdata_r    <= 8'h00;
        end else begin
            state_r <= next_s;
            if ((state_r == IDLE) && req) begin
                rw_r       <= rw;
                reg_addr_r <= reg_addr;
                wdata_r    <= wdata;
            end else begin
                rw_r       <= rw_r;
                reg_addr_r <= reg_addr_r;
                wdata_r    <= wdata_r;
            end
            a_r       <= a_s;
            iorq_n_r  <= iorq_n_s;
            rd_n_r    <= rd_n_s;
            wr_n_r    <= wr_n_s;
            dout_r    <= dout_s;
            dout_oe_r <= dout_oe_s;
            busy_r    <= (next_s != IDLE);
            done_r    <= (next_s == DONE);
            // Sample the slave on the final strobe cycle, while rd_n is still low.
            if ((state_r == D_STROBE) && tc_s && !rw_r) begin
                rdata_r <= din;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign a       = a_r;
    assign iorq_n  = iorq_n_r;
    assign rd_n    = rd_n_r;
    assign wr_n    = wr_n_r;
    assign dout    = dout_r;
    assign dout_oe = dout_oe_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign rdata   = rdata_r;

endmodule

// File: tb/tb_zxuno_regmaster.sv
// Self-checking bench for zxuno_regmaster with an attached ZX-UNO register-decoder model.
// Cycle n spans from edge n-1 to edge n; expectations are kept in a scoreboard queue.
module tb_zxuno_regmaster;

    localparam int          P      = 2;
    localparam logic [15:0] IOADDR = 16'hFC3B;
    localparam logic [15:0] IODATA = 16'hFD3B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic [7:0]  reg_addr = 8'h00;
    logic [7:0]  wdata = 8'h00;
    logic        busy, done, iorq_n, rd_n, wr_n, dout_oe;
    logic [7:0]  rdata, dout, din;
    logic [15:0] a;

    zxuno_regmaster #(
        .IOADDR     (IOADDR),
        .IODATA     (IODATA),
        .PHASE_CLKS (P)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .rw       (rw),
        .reg_addr (reg_addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .a        (a),
        .iorq_n   (iorq_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .dout     (dout),
        .dout_oe  (dout_oe),
        .din      (din)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rw;
        logic [7:0] addr;
        logic [7:0] data;
        int         done_cyc;
        bit         hit;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_regs [256];
    logic [7:0] last_rdata;
    int         checks = 0;
    int         errors = 0;
    int         edge_cnt = 0;
    bit         cur_read = 1'b0;

    // Register-decoder model: latches the index on IOADDR writes, stores/returns data on IODATA.
    logic [7:0] dec_idx;
    logic [7:0] dec_regs [256];
    always @(posedge clk) begin
        if (!rst_n) begin
            dec_regs[8'h80] <= 8'hC3;
        end else if (!iorq_n && !wr_n && a == IOADDR) begin
            dec_idx <= dout;
        end else if (!iorq_n && !wr_n && a == IODATA) begin
            dec_regs[dec_idx] <= dout;
        end
    end
    assign din = (!iorq_n && !rd_n && a == IODATA) ? dec_regs[dec_idx] : 8'hFF;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Bus monitor: strobe counts, first strobe cycle and the data seen during strobes.
    logic idx_low, dwr_low, drd_low, idx_low_q, dat_low_q;
    int   idx_cnt = 0, dwr_cnt = 0, drd_cnt = 0, both_cnt = 0, oe_rd_cnt = 0, done_cnt = 0;
    int   idx_start = 0, dat_start = 0;
    logic [7:0] idx_dout, dat_dout;
    assign idx_low = !iorq_n && !wr_n && (a == IOADDR);
    assign dwr_low = !iorq_n && !wr_n && (a == IODATA);
    assign drd_low = !iorq_n && !rd_n && (a == IODATA);
    always @(negedge clk) begin
        idx_low_q <= idx_low;
        dat_low_q <= dwr_low || drd_low;
        if (idx_low) begin
            idx_cnt  <= idx_cnt + 1;
            idx_dout <= dout;
            if (!idx_low_q) idx_start <= edge_cnt + 1;
        end
        if (dwr_low || drd_low) begin
            dat_dout <= dout;
            if (!dat_low_q) dat_start <= edge_cnt + 1;
        end
        if (dwr_low) dwr_cnt <= dwr_cnt + 1;
        if (drd_low) drd_cnt <= drd_cnt + 1;
        if (!rd_n && !wr_n) both_cnt <= both_cnt + 1;
        if (cur_read && busy && dout_oe && a == IODATA) oe_rd_cnt <= oe_rd_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 7;
        if (iorq_n !== 1'b1)   begin errors++; $display("FAIL reset_iorq_n got %b exp 1", iorq_n); end
        if (rd_n !== 1'b1)     begin errors++; $display("FAIL reset_rd_n got %b exp 1", rd_n); end
        if (wr_n !== 1'b1)     begin errors++; $display("FAIL reset_wr_n got %b exp 1", wr_n); end
        if (dout_oe !== 1'b0)  begin errors++; $display("FAIL reset_dout_oe got %b exp 0", dout_oe); end
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done);
        end
        if (rdata !== 8'h00)   begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
        if (a !== 16'h0000)    begin errors++; $display("FAIL reset_a got %h exp 0000", a); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rdata = 8'h00;
    endtask

    // Wait for done with a cycle budget; pop the scoreboard entry and check the whole operation.
    task automatic finish_op(input int k, input int b_idx, input int b_dwr, input int b_drd,
                             input int b_both, input int b_oe);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL done_timeout got none exp done by cycle %0d", sb[0].done_cyc);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        checks += 5;
        if (edge_cnt + 1 != e.done_cyc) begin
            errors++; $display("FAIL done_cycle got k+%0d exp k+%0d", edge_cnt + 1 - k, e.done_cyc - k);
        end
        if (idx_cnt - b_idx != (e.hit ? 0 : P)) begin
            errors++; $display("FAIL idx_strobe_width got %0d exp %0d", idx_cnt - b_idx, e.hit ? 0 : P);
        end
        if (dat_start != k + (e.hit ? 0 : 3 * P) + P + 1) begin
            errors++; $display("FAIL data_strobe_start got k+%0d exp k+%0d", dat_start - k, (e.hit ? 0 : 3 * P) + P + 1);
        end
        if (both_cnt != b_both) begin
            errors++; $display("FAIL rd_wr_overlap got %0d exp 0", both_cnt - b_both);
        end
        if (e.rw) begin
            if (dwr_cnt - b_dwr != P || drd_cnt != b_drd || dat_dout !== e.data) begin
                errors++; $display("FAIL data_write got wr%0d rd%0d dout %h exp wr%0d rd0 dout %h",
                                   dwr_cnt - b_dwr, drd_cnt - b_drd, dat_dout, P, e.data);
            end
        end else begin
            if (drd_cnt - b_drd != P || dwr_cnt != b_dwr || oe_rd_cnt != b_oe) begin
                errors++; $display("FAIL data_read got rd%0d wr%0d oe%0d exp rd%0d wr0 oe0",
                                   drd_cnt - b_drd, dwr_cnt - b_dwr, oe_rd_cnt - b_oe, P);
            end
        end
        if (!e.hit) begin
            checks++;
            if (idx_start != k + P + 1 || idx_dout !== e.addr) begin
                errors++; $display("FAIL idx_phase got start k+%0d dout %h exp start k+%0d dout %h",
                                   idx_start - k, idx_dout, P + 1, e.addr);
            end
        end
        checks += 2;
        if (e.rw) begin
            if (dec_idx !== e.addr || dec_regs[e.addr] !== e.data) begin
                errors++; $display("FAIL decoder_write got idx %h reg %h exp idx %h reg %h",
                                   dec_idx, dec_regs[e.addr], e.addr, e.data);
            end
            if (rdata !== last_rdata) begin
                errors++; $display("FAIL rdata_hold got %h exp %h", rdata, last_rdata);
            end
        end else begin
            if (rdata !== e.data) begin
                errors++; $display("FAIL read_data got %h exp %h", rdata, e.data);
            end
            last_rdata = e.data;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL busy_in_done got %b exp 1", busy);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse_end got done %b busy %b exp 0 0", done, busy);
        end
        cur_read = 1'b0;
    endtask

    task automatic run_op(input bit op_rw, input logic [7:0] addr, input logic [7:0] data, input bit exp_hit);
        exp_t e;
        int   k, b_idx, b_dwr, b_drd, b_both, b_oe;
        @(posedge clk); #1;
        b_idx = idx_cnt; b_dwr = dwr_cnt; b_drd = drd_cnt; b_both = both_cnt; b_oe = oe_rd_cnt;
        req = 1'b1; rw = op_rw; reg_addr = addr; wdata = data;
        cur_read = !op_rw;
        k = edge_cnt + 1;
        e.rw = op_rw; e.addr = addr; e.hit = exp_hit;
        e.data = op_rw ? data : exp_regs[addr];
        e.done_cyc = k + (exp_hit ? 3 : 6) * P + 1;
        if (op_rw) exp_regs[addr] = data;
        sb.push_back(e);
        @(posedge clk); #1;
        req = 1'b0; rw = ~op_rw; reg_addr = ~addr; wdata = ~data;
        finish_op(k, b_idx, b_dwr, b_drd, b_both, b_oe);
    endtask

    task automatic test_write();
        run_op(1'b1, 8'h0B, 8'h5A, 1'b0);
    endtask

    task automatic test_read();
        run_op(1'b0, 8'h80, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit second_hit;
`ifdef ZXUNO_REGMASTER_ADDRCACHE_EN
        second_hit = 1'b1;
`else
        second_hit = 1'b0;
`endif
        run_op(1'b1, 8'h0B, 8'h11, 1'b0);
        run_op(1'b1, 8'h0B, 8'h22, second_hit);
    endtask

    // Mode 0: extra req pulses at k+3 and in DONE; mode 1: req held high through DONE.
    task automatic test_request_filtering();
        exp_t e;
        int   k, b_idx, b_dwr, b_drd, b_both, b_oe, b_done;
        bit   got;
        for (int mode = 0; mode < 2; mode++) begin
            @(posedge clk); #1;
            b_idx = idx_cnt; b_dwr = dwr_cnt; b_drd = drd_cnt; b_both = both_cnt; b_oe = oe_rd_cnt;
            b_done = done_cnt;
            req = 1'b1; rw = 1'b1; reg_addr = 8'h3C; wdata = (mode == 0) ? 8'h96 : 8'hA5;
            k = edge_cnt + 1;
            e.rw = 1'b1; e.addr = 8'h3C; e.data = wdata;
`ifdef ZXUNO_REGMASTER_ADDRCACHE_EN
            e.hit = (mode == 1);
`else
            e.hit = 1'b0;
`endif
            e.done_cyc = k + (e.hit ? 3 : 6) * P + 1;
            exp_regs[8'h3C] = wdata;
            sb.push_back(e);
            @(posedge clk); #1;
            if (mode == 0) begin
                req = 1'b0;
                repeat (2) @(posedge clk);
                #1 req = 1'b1;
                @(posedge clk); #1;
                req = 1'b0;
            end
            got = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (done === 1'b1) begin got = 1'b1; break; end
            end
            req = 1'b1;
            @(posedge clk); #1;
            req = 1'b0;
            repeat (10) @(negedge clk);
            e = sb.pop_front();
            checks += 3;
            if (!got) begin
                errors++; $display("FAIL filter_timeout mode %0d got none exp done", mode);
            end
            if (done_cnt - b_done != 1 || busy !== 1'b0) begin
                errors++; $display("FAIL filter_done_count mode %0d got %0d busy %b exp 1 busy 0",
                                   mode, done_cnt - b_done, busy);
            end
            if (idx_cnt - b_idx != (e.hit ? 0 : P) || dwr_cnt - b_dwr != P) begin
                errors++; $display("FAIL filter_bus_cycles mode %0d got idx%0d dat%0d exp idx%0d dat%0d",
                                   mode, idx_cnt - b_idx, dwr_cnt - b_dwr, e.hit ? 0 : P, P);
            end
        end
    endtask

    task automatic test_reset_mid_cycle();
        int b_done;
        bit got;
        @(posedge clk); #1;
        b_done = done_cnt;
        req = 1'b1; rw = 1'b1; reg_addr = 8'h22; wdata = 8'h77;
        @(posedge clk); #1;
        req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dwr_low) begin got = 1'b1; break; end
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks += 3;
        if (!got) begin
            errors++; $display("FAIL midreset_no_dstrobe got none exp D_STROBE");
        end
        if (iorq_n !== 1'b1 || wr_n !== 1'b1 || dout_oe !== 1'b0) begin
            errors++; $display("FAIL midreset_strobes got iorq %b wr %b oe %b exp 1 1 0", iorq_n, wr_n, dout_oe);
        end
        if (busy !== 1'b0) begin
            errors++; $display("FAIL midreset_busy got %b exp 0", busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rdata = 8'h00;
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt != b_done) begin
            errors++; $display("FAIL midreset_done got %0d pulses exp 0", done_cnt - b_done);
        end
        run_op(1'b1, 8'h22, 8'h44, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) exp_regs[i] = 8'h00;
        exp_regs[8'h80] = 8'hC3;
        last_rdata = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_request_filtering();
        test_reset_mid_cycle();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_left got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
